// File: rtl/sqrt_arbiter_if.sv
// Bundle of the requester-side and sqrt-unit-side signals of sqrt_arbiter.
// The slave modport is the arbiter's view; master is the surrounding FPU/sqrt side.
interface sqrt_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int W     = 32
);
   logic [N_REQ-1:0]   req;
   logic [N_REQ*W-1:0] operand_i;
   logic [N_REQ-1:0]   grant;
   logic [N_REQ-1:0]   done_o;
   logic [W-1:0]       result_o;
   logic               err;
   logic               busy;
   logic               sqrt_start;
   logic [W-1:0]       sqrt_operand;
   logic               sqrt_done;
   logic [W-1:0]       sqrt_result;

   modport slave (
      input  req, operand_i, sqrt_done, sqrt_result,
      output grant, done_o, result_o, err, busy, sqrt_start, sqrt_operand
   );

   modport master (
      output req, operand_i, sqrt_done, sqrt_result,
      input  grant, done_o, result_o, err, busy, sqrt_start, sqrt_operand
   );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative sqrt unit among N_REQ requesters.
// Optional WAIT timeout abort is built only when SQRT_ARB_TIMEOUT_EN is defined.
module sqrt_arbiter #(
   parameter int N_REQ   = 4,
   parameter int W       = 32,
   parameter int TIMEOUT = 64
) (
   input logic           clk,
   input logic           rst,
   sqrt_arbiter_if.slave bus
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LOAD = 3'd1;
   localparam logic [2:0] RUN  = 3'd2;
   localparam logic [2:0] WAIT = 3'd3;
   localparam logic [2:0] RESP = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    gidx_q, gidx_d;
   logic [W-1:0]     result_q, result_d;
   logic [W-1:0]     operand_q, operand_d;
   logic             err_q, err_d;
   logic             timeout_hit;
   logic             win_found;
   logic [IW-1:0]    win_idx;
   logic [IW:0]      cand;
   logic [W-1:0]     win_operand;
   logic [N_REQ-1:0] owner_mask;

   // First requester at or after ptr, wrapping modulo N_REQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(k);
         if (cand >= (IW+1)'(N_REQ)) begin
            cand = cand - (IW+1)'(N_REQ);
         end
         if (!win_found && bus.req[cand[IW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      win_operand = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_idx == IW'(i)) begin
            win_operand = bus.operand_i[i*W +: W];
         end
      end
   end

`ifdef SQRT_ARB_TIMEOUT_EN
   logic [7:0] tcnt_q, tcnt_d;

   always_comb begin
      tcnt_d = tcnt_q;
      if (state_q == RUN) begin
         tcnt_d = '0;
      end else if (state_q == WAIT && !bus.sqrt_done) begin
         tcnt_d = tcnt_q + 8'd1;
      end
   end

   // Fires on the WAIT cycle whose increment would bring the count to TIMEOUT.
   assign timeout_hit = (state_q == WAIT) && !bus.sqrt_done &&
                        (tcnt_q == 8'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcnt_q <= '0;
      end else begin
         tcnt_q <= tcnt_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gidx_d    = gidx_q;
      result_d  = result_q;
      operand_d = operand_q;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d   = LOAD;
               gidx_d    = win_idx;
               operand_d = win_operand;
            end
         end
         LOAD: state_d = RUN;
         RUN:  state_d = WAIT;
         WAIT: begin
            if (bus.sqrt_done) begin
               state_d  = RESP;
               result_d = bus.sqrt_result;
            end else if (timeout_hit) begin
               state_d  = RESP;
               result_d = '1;
               err_d    = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
            ptr_d   = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + IW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         gidx_q    <= '0;
         result_q  <= '0;
         operand_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gidx_q    <= gidx_d;
         result_q  <= result_d;
         operand_q <= operand_d;
         err_q     <= err_d;
      end
   end

   assign owner_mask       = N_REQ'(1) << gidx_q;
   assign bus.grant        = (state_q != IDLE) ? owner_mask : '0;
   assign bus.done_o       = (state_q == RESP) ? owner_mask : '0;
   assign bus.busy         = (state_q != IDLE);
   assign bus.sqrt_start   = (state_q == RUN);
   assign bus.result_o     = result_q;
   assign bus.sqrt_operand = operand_q;
   assign bus.err          = err_q;
endmodule

// File: doc/sqrt_arbiter.md
# sqrt_arbiter

Round-robin arbiter and sequencer sharing one iterative square-root unit among `N_REQ` requesters in the FPU. It selects one pending requester, captures its operand, issues a one-cycle start pulse to the sqrt datapath, and waits for the datapath's done. It then returns the result with a one-cycle done pulse to the granted requester. It sits between the FPU issue logic and the sqrt input wrapper/datapath.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `W`, 32, operand/result width
- `TIMEOUT`, 64, maximum WAIT cycles before abort (used only with `SQRT_ARB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  `N_REQ`  per-requester level request; held until that requester's `done_o` bit pulses
- `operand_i`  in  `N_REQ*W`  packed operands; requester i occupies bits `[i*W +: W]`
- `grant`  out  `N_REQ`  one-hot owner of the sqrt unit; all zeros when idle
- `done_o`  out  `N_REQ`  one-cycle completion pulse to the owner
- `result_o`  out  `W`  last result, held until the next completion
- `err`  out  1  one-cycle timeout pulse, coincident with `done_o`
- `busy`  out  1  high in every state except IDLE
- `sqrt_start`  out  1  one-cycle start pulse to the sqrt unit
- `sqrt_operand`  out  `W`  registered operand, stable from LOAD until return to IDLE
- `sqrt_done`  in  1  completion from the sqrt unit
- `sqrt_result`  in  `W`  sqrt result, valid while `sqrt_done` is high

## Operation
- FSM states: IDLE, LOAD, RUN, WAIT, RESP.
- IDLE → LOAD when any `req` bit is high; otherwise stay in IDLE.
- LOAD → RUN unconditionally. RUN → WAIT unconditionally.
- WAIT → RESP when `sqrt_done` is high (or on timeout, see Configuration).
- RESP → IDLE unconditionally. There is no back-to-back issue; at least one IDLE cycle occurs between jobs.
- Arbitration happens on the IDLE→LOAD edge:
  - Search starts at index `ptr`, wrapping modulo `N_REQ`; the first set `req` bit wins.
  - The winning index is registered as `gidx`.
  - `sqrt_operand` is loaded from slot `gidx` on the same edge.
- `grant[gidx]` is high from LOAD through RESP.
- `sqrt_start` is high only in RUN.
- On the WAIT→RESP edge, `result_o` latches `sqrt_result`.
- On the RESP→IDLE edge, `ptr` becomes `(gidx+1) mod N_REQ`.
- `done_o[gidx]` is high only in RESP.
- Dropping `req` mid-job has no effect: the job completes and `done_o` still pulses.
- `sqrt_done` is ignored in IDLE, LOAD, RUN and RESP; only its value in WAIT is used.
- Reset values: state IDLE, `ptr`=0, `gidx`=0, `grant`=0, `done_o`=0, `result_o`=0, `sqrt_operand`=0, `sqrt_start`=0, `busy`=0, `err`=0, timeout counter 0.
- Reset mid-job aborts immediately. No `done_o` is issued for the aborted job.

## Timing
- Cycle 0: IDLE with `req` sampled high.
- Cycle 1: LOAD; `grant` high, `busy` high.
- Cycle 2: RUN; `sqrt_start`=1.
- Cycle 3 onward: WAIT.
- If `sqrt_done` is first sampled high in WAIT at cycle k, then RESP is at cycle k+1 (`done_o`, `result_o` valid) and IDLE is at cycle k+2.
- Minimum request-to-done latency is 4 cycles (`sqrt_done` high in the first WAIT cycle).
- Fairness: a continuously requesting port waits at most `N_REQ-1` jobs.

## Configuration
- `SQRT_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle without `sqrt_done`.
  - On the edge where the count reaches `TIMEOUT` with `sqrt_done` still low, the FSM goes to RESP.
  - In that RESP, `err`=1 and `result_o` is loaded with all ones (NaN pattern).
  - `done_o` pulses as normal and `ptr` advances as normal.
  - If `sqrt_done` and the timeout coincide, `sqrt_done` wins and `err`=0.
- Not defined: no counter is built, WAIT lasts until `sqrt_done`, and `err` is tied to 0.

## Test plan
- Reset, then `req`=4'b0001 with operand 32'h40800000 (4.0); model returns 32'h40000000 with `sqrt_done` 3 cycles after start → `grant`=0001 at cycle 1, `sqrt_start` at cycle 2, `done_o`=0001 with `result_o`=32'h40000000 exactly one cycle after `sqrt_done`.
- `req`=4'b1111 held for 8 jobs → grant order 0,1,2,3,0,1,2,3, with exactly one IDLE cycle between jobs.
- `req`=4'b1010 after a job on port 3 (`ptr` wraps to 0) → port 1 granted, then port 3.
- `req[2]` dropped during WAIT → `done_o[2]` still pulses; the next IDLE does not grant port 2.
- `rst` asserted low during WAIT → all outputs 0 asynchronously; after release, `req`=4'b0100 is granted (ptr=0 search) with a clean 4-cycle minimum latency.
- With `SQRT_ARB_TIMEOUT_EN` and `TIMEOUT`=64, `sqrt_done` never asserted → RESP 64 WAIT cycles after entry; `err`=1, `result_o`=32'hFFFFFFFF, `done_o` pulses; a second run with `sqrt_done` on the final WAIT cycle gives `err`=0.
